// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// master = producer/consumer side, slave = the adder.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry look-ahead adder/subtractor: one BLOCK-bit group resolved per stage,
// group carry registered between stages, valid/ready with a global stall enable.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  cla_pipe_adder_if.slave   bus
);

  localparam int unsigned NUM_BLK = WIDTH / BLOCK;

  if (WIDTH == 0 || BLOCK == 0 || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  // Flat sum-of-products carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci.
  function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] p,
                                               input logic [BLOCK-1:0] g,
                                               input logic             ci);
    logic [BLOCK:0] c;
    logic           term;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic [NUM_BLK-1:0]            vld_q, vld_d;
  logic [NUM_BLK-1:0]            cy_q, cy_d;
  logic [NUM_BLK-1:0][WIDTH-1:0] a_q, a_d;
  logic [NUM_BLK-1:0][WIDTH-1:0] bp_q, bp_d;
  logic [NUM_BLK-1:0][WIDTH-1:0] sum_q, sum_d;
  logic                          ovf_q, ovf_d;
  logic                          adv;

  assign adv          = ~vld_q[NUM_BLK-1] | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_stage
    logic [WIDTH-1:0] src_a, src_bp, src_sum, nsum;
    logic             src_cy, src_vld;
    logic [BLOCK-1:0] p, g;
    logic [BLOCK:0]   c;

    if (k == 0) begin : g_first
      assign src_vld = bus.in_valid;
      assign src_a   = bus.a;
      assign src_bp  = bus.sub ? ~bus.b : bus.b;
      assign src_cy  = bus.sub | bus.cin;
      assign src_sum = '0;
    end else begin : g_next
      assign src_vld = vld_q[k-1];
      assign src_a   = a_q[k-1];
      assign src_bp  = bp_q[k-1];
      assign src_cy  = cy_q[k-1];
      assign src_sum = sum_q[k-1];
    end

    assign p = src_a[k*BLOCK +: BLOCK] ^ src_bp[k*BLOCK +: BLOCK];
    assign g = src_a[k*BLOCK +: BLOCK] & src_bp[k*BLOCK +: BLOCK];
    assign c = lookahead(p, g, src_cy);

    always_comb begin
      nsum                    = src_sum;
      nsum[k*BLOCK +: BLOCK]  = p ^ c[BLOCK-1:0];
    end

    assign vld_d[k] = src_vld;
    assign a_d[k]   = src_a;
    assign bp_d[k]  = src_bp;
    assign cy_d[k]  = c[BLOCK];
    assign sum_d[k] = nsum;

    if (k == NUM_BLK - 1) begin : g_last
      assign ovf_d = c[BLOCK] ^ c[BLOCK-1];
    end
  end

  // Operands leaving the final stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_q[NUM_BLK-1], bp_q[NUM_BLK-1]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      cy_q  <= '0;
      a_q   <= '0;
      bp_q  <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      a_q   <= a_d;
      bp_q  <= bp_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out_valid = vld_q[NUM_BLK-1];
  assign bus.sum       = sum_q[NUM_BLK-1];
  assign bus.c_out     = cy_q[NUM_BLK-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry look-ahead adder/subtractor; successor to the team's fixed 4-bit combinational CLA.
- WIDTH-bit operands are split into BLOCK-bit look-ahead groups, with one group resolved per pipeline stage. The group carry is registered between stages.
- A valid/ready handshake on both sides lets the block sit directly in datapath pipelines (ALU, accumulator, address generation).
- Throughput is one operation per cycle.

Parameters:
- WIDTH, 16, operand/sum width; must be an integer multiple of BLOCK (elaboration error otherwise).
- BLOCK, 4, bits per look-ahead group; NUM_BLK = WIDTH/BLOCK = pipeline depth.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- Cin  in  1  carry-in, used in add mode only.
- sub  in  1  0 = A+B+Cin, 1 = A-B (A + ~B + 1; Cin ignored).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result bits.
- C_out  out  1  carry out of MSB; in sub mode 1 = no borrow (A >= B unsigned).
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0 at clk edge): all stage valid bits cleared; out_valid=0, sum=0, C_out=0, ovf=0. in_ready is 1 from the first cycle after reset. Reset mid-operation discards all in-flight ops, with no partial output.
- Group logic per stage: p_i = a_i^b'_i, g_i = a_i&b'_i, with b' = sub ? ~b : b.
  - In-group carries use full look-ahead (each c_i a flat sum of products of p/g and the group carry-in), not ripple.
  - Group sum bit = p_i ^ c_i.
- Stage 0 captures a, b', effective carry-in (sub ? 1 : Cin) and resolves bits [BLOCK-1:0].
- Stage k (1..NUM_BLK-1) resolves bits [BLOCK*(k+1)-1 : BLOCK*k] using the registered carry from stage k-1.
- Unresolved operand bits travel with the op; resolved sum bits accumulate in place.
- Latency: an op accepted at edge T (in_valid & in_ready) presents out_valid=1 with its result after edge T+NUM_BLK-1 (4 cycles for the defaults, counting the accept edge as the first), assuming no stall.
- Stall: advance = !out_valid | out_ready; in_ready = advance.
  - All stages move together when advance=1 and hold otherwise (global enable, no bubble collapse).
  - in_ready is combinational from out_valid/out_ready only; it never depends on in_valid.
- While out_valid=1 and out_ready=0: sum, C_out and ovf hold stable and no stage register changes.
- Bubbles: in_valid=0 on an advancing cycle inserts a stage-0 valid=0 slot. Bubbles flow through without altering data ordering.
- Ordering: results emerge strictly in acceptance order, one per out_valid&out_ready handshake; no op is dropped or duplicated.
- Simultaneous accept and output handshake in the same cycle is legal; the pipeline stays full at 1 op/cycle.
- Width rules: sum is WIDTH bits, modulo 2^WIDTH. C_out is the carry out of bit WIDTH-1. ovf uses the carry into bit WIDTH-1 and C_out.
- Outputs are fully registered; no combinational path from a/b/Cin/sub to any output.

Test Plan:
- Reset then single add (defaults): a=16'h1234, b=16'h0FCD, Cin=1, sub=0 -> exactly 4 cycles later sum=16'h2202, C_out=0, ovf=0; out_valid high for one cycle with out_ready=1.
- Full carry chain across all groups: a=16'hFFFF, b=16'h0000, Cin=1 -> sum=16'h0000, C_out=1, ovf=0. Then a=16'h7FFF, b=16'h0001, Cin=0 -> sum=16'h8000, C_out=0, ovf=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1, Cin=1 (ignored) -> sum=16'hFFFE, C_out=0. Then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, C_out=1, ovf=1.
- Back-to-back stream with backpressure: 8 consecutive ops, out_ready low for 3 cycles mid-stream -> in_ready low the same cycles, held output stable, all 8 results in order, no loss/duplication.
- Reset mid-flight: 3 ops accepted, rst_n=0 for one edge -> out_valid=0, sum=0, C_out=0, ovf=0 next cycle; none of the 3 results ever appear.
- Parameter sweep (WIDTH=8/BLOCK=4, WIDTH=32/BLOCK=8, WIDTH=12/BLOCK=3): 10k random ops with random in_valid/out_ready compared against a behavioural a+b+Cin / a-b model; latency equals NUM_BLK.
